// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains a counted burst from a FIFO read port onto a ready/valid stream
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    localparam int LW        = ADDR_WIDTH + 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  start,
    input  logic [LW-1:0]         burst_len,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LW-1:0]         xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         remaining_q, remaining_d;
    logic [LW-1:0]         xfer_count_q, xfer_count_d;
    logic [LW-1:0]         len_q, len_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  done_q, done_d;
    logic                  rinc_c;
    logic                  accept;

    // Pop only when a word is still owed and the output register is free or being emptied this cycle
    always_comb begin
        rinc_c = rrst_n && (state_q == BURST) && (remaining_q != '0) && !rempty
                 && (!m_valid_q || m_ready);
        accept = m_valid_q && m_ready;
    end

    // Next-state and datapath: output register load/clear, word counters, burst sequencing
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        xfer_count_d = xfer_count_q;
        len_d        = len_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        done_d       = 1'b0;

        if (accept && (xfer_count_q < len_q)) begin
            xfer_count_d = xfer_count_q + LW'(1);
        end

        if (rinc_c) begin
            m_data_d    = rdata;
            m_valid_d   = 1'b1;
            remaining_d = remaining_q - LW'(1);
        end else if (accept) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    xfer_count_d = '0;
                    len_d        = burst_len;
                    if (burst_len != '0) begin
                        state_d     = BURST;
                        remaining_d = burst_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BURST: begin
                // Last word popped: wait in DRAIN unless nothing is left in the output register
                if (remaining_d == '0) begin
                    if (m_valid_d) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset discards any held word
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            xfer_count_q <= '0;
            len_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            xfer_count_q <= xfer_count_d;
            len_q        <= len_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            done_q       <= done_d;
        end
    end

    assign rinc       = rinc_c;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int LW = AW + 1;

    logic          rclk;
    logic          rrst_n;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic [LW-1:0] xfer_count;

    fifo_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .start(start), .burst_len(burst_len),
        .rempty(rempty), .rdata(rdata), .rinc(rinc), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done),
        .xfer_count(xfer_count)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        int len;
        bit rnd_ready;
        bit start_mid;
        bit fixed_data;
        int exp_xfer;
    } vec_t;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] sb[$];
    int checks = 0;
    int failures = 0;
    int tick_n = 0;
    int pops, accepts, done_count, first_pop, last_pop, last_acc, done_tick;
    bit stall_prev = 0;
    logic [DW-1:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick_n);
        end
    endtask

    task automatic clr();
        pops = 0; accepts = 0; done_count = 0;
        first_pop = -1; last_pop = -1; last_acc = -1; done_tick = -1;
    endtask

    task automatic preload(input int n, input bit fixed);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = fixed ? DW'(8'h11 * (i + 1)) : DW'($urandom_range(0, 255));
            fifo.push_back(w);
            sb.push_back(w);
        end
    endtask

    // One cycle: present FIFO model at the negedge, observe before the posedge, then advance
    task automatic tick();
        logic [DW-1:0] exp_w;
        rempty = (fifo.size() == 0);
        rdata  = rempty ? '0 : fifo[0];
        #1;
        if (!rrst_n) chk("rinc_in_reset", rinc, 0);
        if (stall_prev) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, held);
        end
        if (m_valid && !m_ready) chk("stall_rinc", rinc, 0);
        if (rinc) begin
            chk("rinc_not_empty", rempty, 0);
            chk("rinc_busy", busy, 1);
            if (fifo.size() != 0) void'(fifo.pop_front());
            pops++;
            if (first_pop < 0) first_pop = tick_n;
            last_pop = tick_n;
        end
        if (m_valid && m_ready && rrst_n) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                exp_w = sb.pop_front();
                chk("m_data", m_data, exp_w);
            end
            accepts++;
            last_acc = tick_n;
        end
        if (done) begin
            done_count++;
            done_tick = tick_n;
        end
        stall_prev = rrst_n && m_valid && !m_ready;
        held = m_data;
        @(posedge rclk);
        @(negedge rclk);
        tick_n++;
    endtask

    task automatic run_burst(input vec_t v);
        clr();
        preload(v.len, v.fixed_data);
        start = 1; burst_len = LW'(v.len); m_ready = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3000 && done_count == 0; i++) begin
            m_ready = v.rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (v.start_mid && i == 2) begin
                start = 1; burst_len = LW'(2);
            end else start = 0;
            tick();
        end
        start = 0; m_ready = 1;
        tick();
        chk("done_count", done_count, 1);
        chk("pops", pops, v.len);
        chk("accepts", accepts, v.exp_xfer);
        chk("xfer_count", xfer_count, v.exp_xfer);
        chk("busy_after", busy, 0);
        chk("done_after_last_acc", done_tick, last_acc + 1);
        chk("sb_empty", sb.size(), 0);
        if (!v.rnd_ready) chk("throughput", last_pop - first_pop, v.len - 1);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{len: 4,  rnd_ready: 0, start_mid: 0, fixed_data: 1, exp_xfer: 4};
        vecs[1] = '{len: 3,  rnd_ready: 1, start_mid: 1, fixed_data: 0, exp_xfer: 3};
        vecs[2] = '{len: 1,  rnd_ready: 0, start_mid: 0, fixed_data: 0, exp_xfer: 1};
        vecs[3] = '{len: 7,  rnd_ready: 1, start_mid: 0, fixed_data: 0, exp_xfer: 7};
        vecs[4] = '{len: 16, rnd_ready: 1, start_mid: 1, fixed_data: 0, exp_xfer: 16};
        vecs[5] = '{len: 64, rnd_ready: 0, start_mid: 0, fixed_data: 0, exp_xfer: 64};

        rrst_n = 0; start = 0; burst_len = '0; m_ready = 1; rempty = 1; rdata = '0;
        clr();
        @(negedge rclk);
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_done", done, 0);
        chk("rst_xfer_count", xfer_count, 0);
        rrst_n = 1;
        tick();

        foreach (vecs[i]) run_burst(vecs[i]);

        // Explicit two-cycle stall right after the first word
        clr();
        preload(3, 0);
        start = 1; burst_len = LW'(3); m_ready = 1;
        tick();
        start = 0; m_ready = 0;
        tick(); tick(); tick();
        chk("stall_pops", pops, 1);
        chk("stall_valid", m_valid, 1);
        m_ready = 1;
        for (int i = 0; i < 20 && done_count == 0; i++) tick();
        chk("stall_done", done_count, 1);
        chk("stall_total_pops", pops, 3);
        chk("stall_xfer", xfer_count, 3);

        // Zero-length burst: no pop, done next cycle, count cleared
        clr();
        start = 1; burst_len = '0;
        tick();
        start = 0;
        tick();
        chk("len0_done", done_count, 1);
        chk("len0_pops", pops, 0);
        chk("len0_m_valid", m_valid, 0);
        chk("len0_xfer", xfer_count, 0);
        tick();
        chk("len0_done_width", done_count, 1);

        // FIFO runs dry mid-burst, then refills
        clr();
        preload(2, 0);
        start = 1; burst_len = LW'(5); m_ready = 1;
        tick();
        start = 0;
        repeat (8) tick();
        chk("dry_pops", pops, 2);
        chk("dry_busy", busy, 1);
        chk("dry_no_done", done_count, 0);
        preload(3, 0);
        for (int i = 0; i < 50 && done_count == 0; i++) tick();
        chk("refill_pops", pops, 5);
        chk("refill_xfer", xfer_count, 5);
        chk("refill_done", done_count, 1);

        // Reset during a 64-word burst with a word in flight
        clr();
        preload(64, 0);
        start = 1; burst_len = LW'(64); m_ready = 1;
        tick();
        start = 0;
        repeat (10) tick();
        chk("pre_reset_valid", m_valid, 1);
        rrst_n = 0;
        tick();
        rrst_n = 1;
        fifo.delete(); sb.delete(); stall_prev = 0;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_m_data", m_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_xfer", xfer_count, 0);
        tick(); tick();
        chk("abort_no_done", done_count, 0);
        run_burst(vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: rclk and rrst_n; all state changes on rising rclk.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the FIFO read-data and stream-data width.
REQ-003 Parameter ADDR_WIDTH, default 6, SHALL set the FIFO address width; the length/count width SHALL be LW = ADDR_WIDTH+1.
REQ-004 Ports (name  direction  width  meaning):
- rclk  in  1  read-domain clock
- rrst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle burst request, sampled only in IDLE
- burst_len  in  LW  words to drain, sampled with start
- rempty  in  1  FIFO read-side empty flag
- rdata  in  DATA_WIDTH  FIFO head word, valid while rempty=0
- rinc  out  1  FIFO pop strobe
- m_valid  out  1  stream word valid
- m_data  out  DATA_WIDTH  stream word
- m_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- done  out  1  one-cycle burst-complete pulse
- xfer_count  out  LW  words accepted downstream in current/last burst

Function
REQ-005 States SHALL be IDLE, BURST, DRAIN.
REQ-006 IDLE: start=1 with burst_len>0 -> BURST; remaining<=burst_len, xfer_count<=0.
REQ-007 IDLE: start=1 with burst_len=0 -> stay IDLE; done=1 next cycle; xfer_count<=0; no rinc.
REQ-008 start outside IDLE SHALL be ignored.
REQ-009 rinc SHALL be combinational: rinc = (state==BURST) & (remaining!=0) & !rempty & (!m_valid | m_ready).
REQ-010 On an edge with rinc=1, m_data<=rdata, m_valid<=1, remaining decrements by 1.
REQ-011 On an edge with m_valid&m_ready and rinc=0, m_valid<=0; m_data holds.
REQ-012 While m_valid=1 and m_ready=0, m_data and m_valid SHALL hold and rinc SHALL be 0.
REQ-013 Throughput SHALL be one word per cycle with m_ready=1 and rempty=0; FIFO-to-stream latency is one cycle.
REQ-014 rempty=1 mid-burst SHALL stall popping without error; popping resumes the cycle rempty returns to 0.
REQ-015 xfer_count SHALL increment on each m_valid&m_ready edge, saturate at burst_len, and hold after done until the next accepted start.
REQ-016 BURST SHALL move to DRAIN when remaining reaches 0 while the last word is still unaccepted; if the last pop and its acceptance coincide, BURST -> IDLE directly.
REQ-017 DRAIN -> IDLE on the edge accepting the last word; done SHALL be 1 for exactly the following cycle.
REQ-018 rinc SHALL never assert in IDLE or DRAIN; total pops per burst SHALL equal burst_len exactly.
REQ-019 burst_len = 2^ADDR_WIDTH (64) SHALL be supported without counter wrap.

Reset
REQ-020 rrst_n=0 at an rclk edge SHALL force state=IDLE, m_valid=0, m_data=0, done=0, busy=0, xfer_count=0, remaining=0; rinc=0 while rrst_n=0.
REQ-021 Reset mid-burst SHALL abort the burst with no done pulse; an unaccepted m_data word is discarded.

Verification
REQ-022 FIFO holds 0x11,0x22,0x33,0x44; start, burst_len=4, m_ready=1 -> rinc 4 consecutive cycles, m_data 0x11..0x44 in order, done one cycle after last accept, xfer_count=4.
REQ-023 Burst 3, m_ready low 2 cycles after first word -> m_data held at first word, rinc=0 during stall, no loss/duplication, xfer_count=3.
REQ-024 Burst 5 with only 2 words present -> 2 pops, rinc=0 while rempty=1, busy=1; after 3 more writes, 3 further pops and done.
REQ-025 start with burst_len=0 -> no rinc, m_valid=0, done next cycle, xfer_count=0; start during BURST ignored.
REQ-026 rrst_n low 1 cycle mid-burst 64 with m_valid=1 -> all outputs zero next cycle, no done; new start, burst_len=64, full FIFO -> 64 pops, xfer_count=64, done.
